// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI initiator.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } spi_state_t;

  localparam int DEFAULT_FRAME_BITS  = 16;
  localparam int DEFAULT_HALF_PERIOD = 20;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period counter: counts 0..HALF_PERIOD-1, flags expiry, and restarts on expiry or clear.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  if (HALF_PERIOD < 1) begin : g_bad_half_period
    $error("spi_tick_gen: HALF_PERIOD must be >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == CW'(HALF_PERIOD - 1));

  // Every expiry causes a state change in the master, so expiry doubles as reload.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one FRAME_BITS word per start, MSB first, all pins driven from flops.
module spi_master
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] tx_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [FRAME_BITS-1:0] rx_data_o,
  output logic                  sck_o,
  output logic                  sdo_o,
  input  logic                  sdi_i,
  output logic                  cs_n_o
);

  localparam int BCW = $clog2(FRAME_BITS);

  if (FRAME_BITS < 2) begin : g_bad_frame_bits
    $error("spi_master: FRAME_BITS must be >= 2");
  end

  spi_state_t            state_q, state_d;
  logic                  sck_q, sck_d;
  logic                  sdo_q, sdo_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  expire;

  spi_tick_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (state_q == IDLE),
    .expire_o(expire)
  );

  always_comb begin
    state_d    = state_q;
    sck_d      = sck_q;
    sdo_d      = sdo_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          tx_shift_d = tx_data_i;
          sdo_d      = tx_data_i[FRAME_BITS-1];
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          state_d    = SETUP;
        end
      end
      SETUP, LOW: begin
        if (expire) begin
          sck_d   = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        // Sample on the last cycle of the high phase for maximum setup after the slave's fall update.
        if (expire) begin
          rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], sdi_i};
          sck_d      = 1'b0;
          if (bit_cnt_q == BCW'(FRAME_BITS - 1)) begin
            state_d = HOLD;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            sdo_d      = tx_shift_q[FRAME_BITS-2];
            bit_cnt_d  = bit_cnt_q + 1'b1;
            state_d    = LOW;
          end
        end
      end
      HOLD: begin
        if (expire) begin
          cs_n_d    = 1'b1;
          sdo_d     = 1'b0;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      sck_q      <= 1'b0;
      sdo_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign sck_o     = sck_q;
  assign sdo_o     = sdo_q;
  assign cs_n_o    = cs_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench: 16-bit/HP=2 master in loopback or against a mode-0 slave model, plus a 10-bit/HP=1 master.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] tx_data = '0;
  logic        busy, done, sck, sdo, sdi, cs_n;
  logic [15:0] rx_data;

  logic        start2 = 1'b0;
  logic [9:0]  tx_data2 = '0;
  logic        busy2, done2, sck2, sdo2, cs_n2;
  logic [9:0]  rx_data2;

  logic        slave_mode = 1'b0;
  logic [15:0] slv_d = '0;
  logic [15:0] slv_sh, slv_rx;
  logic        sck_d;

  int vectors = 0;
  int errors  = 0;
  int rises = 0, rises_cs = 0, rises2 = 0, done_cnt = 0;
  int lat, r0, rc0, d0, guard;

  always #5 clk = ~clk;

  assign sdi = slave_mode ? slv_sh[15] : sdo;

  spi_master #(.FRAME_BITS(16), .HALF_PERIOD(2)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .tx_data_i(tx_data),
    .busy_o(busy), .done_o(done), .rx_data_o(rx_data),
    .sck_o(sck), .sdo_o(sdo), .sdi_i(sdi), .cs_n_o(cs_n)
  );

  spi_master #(.FRAME_BITS(10), .HALF_PERIOD(1)) dut2 (
    .clk_i(clk), .reset_i(reset), .start_i(start2), .tx_data_i(tx_data2),
    .busy_o(busy2), .done_o(done2), .rx_data_o(rx_data2),
    .sck_o(sck2), .sdo_o(sdo2), .sdi_i(sdo2), .cs_n_o(cs_n2)
  );

  always @(posedge sck) begin
    rises <= rises + 1;
    if (cs_n === 1'b0) rises_cs <= rises_cs + 1;
  end
  always @(posedge sck2) rises2 <= rises2 + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Slave model sampled mid-cycle: loads while deselected, shifts out after sck fall, captures on rise.
  always @(negedge clk) begin
    sck_d <= sck;
    if (cs_n) slv_sh <= slv_d;
    else if (sck_d && !sck) slv_sh <= slv_sh << 1;
    if (!sck_d && sck) slv_rx <= {slv_rx[14:0], sdo};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] d);
    tx_data = d;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Cycles from the accept edge until done is seen; returns the bound on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    // 1: reset held with start asserted
    start = 1'b1;
    repeat (3) tick();
    chk("rst_sck", 32'(sck), 32'h0);
    chk("rst_cs_n", 32'(cs_n), 32'h1);
    chk("rst_sdo", 32'(sdo), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rx", 32'(rx_data), 32'h0);
    start = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_no_frame", 32'(cs_n), 32'h1);

    // 2: loopback A5C3
    r0 = rises; rc0 = rises_cs;
    start_frame(16'hA5C3);
    wait_done(lat);
    chk("lb_latency", 32'(lat), 32'd66);
    chk("lb_rx", 32'(rx_data), 32'hA5C3);
    chk("lb_rises", 32'(rises - r0), 32'd16);
    chk("lb_rises_cs", 32'(rises_cs - rc0), 32'd16);
    tick();

    // 3: slave model
    slave_mode = 1'b1;
    slv_d = 16'h1234;
    tick();
    start_frame(16'h03FF);
    wait_done(lat);
    chk("slv_master_rx", 32'(rx_data), 32'h1234);
    tick();
    chk("slv_slave_rx", 32'(slv_rx), 32'h03FF);
    slave_mode = 1'b0;

    // 4: mid-frame start ignored, then start held through done
    d0 = done_cnt;
    start_frame(16'h5A5A);
    repeat (10) tick();
    tx_data = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_busy", 32'(busy), 32'h1);
    repeat (48) tick();
    tx_data = 16'h0F0F;
    start = 1'b1;
    wait_done(lat);
    chk("b2b_first_lat", 32'(lat), 32'd7);
    chk("b2b_first_rx", 32'(rx_data), 32'h5A5A);
    chk("b2b_gap_cs_n", 32'(cs_n), 32'h1);
    tick();
    start = 1'b0;
    chk("b2b_restart_cs_n", 32'(cs_n), 32'h0);
    chk("b2b_restart_busy", 32'(busy), 32'h1);
    wait_done(lat);
    chk("b2b_second_lat", 32'(lat), 32'd66);
    chk("b2b_second_rx", 32'(rx_data), 32'h0F0F);
    tick();
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // 5: reset after the fifth sck rise
    r0 = rises;
    start_frame(16'h1357);
    guard = 0;
    while ((rises - r0) < 5 && guard < 200) begin
      tick();
      guard++;
    end
    chk("abort_reached_5", 32'(rises - r0), 32'd5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_sck", 32'(sck), 32'h0);
    chk("abort_cs_n", 32'(cs_n), 32'h1);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_rx", 32'(rx_data), 32'h0);
    d0 = done_cnt;
    repeat (100) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    start_frame(16'hBEEF);
    wait_done(lat);
    chk("after_abort_lat", 32'(lat), 32'd66);
    chk("after_abort_rx", 32'(rx_data), 32'hBEEF);
    tick();

    // 6: FRAME_BITS=10, HALF_PERIOD=1 loopback
    r0 = rises2;
    tx_data2 = 10'h2AA;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tx_data2 = 10'h155;
    lat = 0;
    while (done2 !== 1'b1 && lat < 500) begin
      tick();
      lat++;
    end
    chk("small_latency", 32'(lat), 32'd21);
    chk("small_rx", 32'(rx_data2), 32'h2AA);
    chk("small_rises", 32'(rises2 - r0), 32'd10);
    tick();
    chk("small_done_pulse", 32'(done2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
